mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the instruction-fetch and data-access requesters of the pipelined core onto one shared single-ported memory. Grants one transaction at a time, with data priority and a bounded fetch-starvation guarantee, and routes each response back to its owner. Sits between the fetch/memory stages and a unified memory model, replacing separate imemory/dmemory ports.

## Interface
- DATAW, 32, data width
- ADDRW, 32, address width
- STARVE_LIMIT, 4, max consecutive data grants while a fetch is pending (0 = fetch always wins ties)

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  ADDRW  fetch address (always a read, size word)
- if_resp_valid  out  1  one-cycle pulse, fetch data valid
- if_resp_data  out  DATAW  fetch data, held until next fetch response
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_addr  in  ADDRW  data address
- d_rw  in  1  1 = write, 0 = read
- d_size  in  2  access size (funct3[1:0] encoding)
- d_wdata  in  DATAW  store data
- d_resp_valid  out  1  one-cycle pulse: read data valid / write acknowledged
- d_resp_data  out  DATAW  read data; 0 for write acks; held until next data response
- m_req_valid  out  1  request to memory
- m_req_ready  in  1  memory accepts request
- m_addr, m_rw, m_size, m_wdata  out  ADDRW/1/2/DATAW  registered request fields
- m_resp_valid  in  1  memory response (reads and writes)
- m_resp_data  in  DATAW  memory read data
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, REQ, WAIT. Exactly one transaction outstanding.
- IDLE: winner chosen combinationally; winner's *_req_ready = 1, loser's = 0. Nothing valid → stay IDLE. On grant: latch addr/rw/size/wdata (fetch: rw=0, size=2'b10, wdata=0), latch owner bit, go REQ.
- Arbitration with both valid: data wins unless starve_cnt == STARVE_LIMIT, then fetch wins. Single valid requester always wins.
- starve_cnt update at each grant: data granted while if_req_valid=1 → +1, saturating at STARVE_LIMIT; any other grant → 0. Unchanged when no grant.
- REQ: m_req_valid=1 with latched fields, stable until m_req_ready; on ready go WAIT.
- WAIT: on m_resp_valid, capture m_resp_data (0 for writes) into owner's resp_data register, pulse owner's resp_valid next cycle, go IDLE.
- *_req_ready = 0 in REQ and WAIT.
- m_resp_valid outside WAIT is a protocol violation: ignored, no state change.
- Memory contract: m_resp_valid no earlier than cycle after the accepting m_req_ready cycle.

## Timing
- Reset: state IDLE, starve_cnt 0, owner 0; all outputs 0 (ready, resp_valid, resp_data, m_req_valid, m_* fields, busy).
- Reset mid-transaction: transaction abandoned, no response delivered; memory shares the reset.
- Grant cycle T → m_req_valid from T+1. Accept at cycle A → WAIT from A+1. Response at R → *_resp_valid at R+1, IDLE at R+1; new grant possible in R+1.
- Minimum: grant T, accept T+1, response T+2, resp_valid T+3, next grant T+3 (3-cycle throughput per access).
- resp_valid is 1 cycle wide; other requester's resp_valid/resp_data unchanged.

## Test plan
- Lone fetch, addr 0x01000000, m_req_ready=1, response 0x00000013 one cycle later → if_req_ready at T, m_req_valid T+1 with m_rw=0 m_size=2, if_resp_valid pulse T+3 data 0x00000013, d_resp_valid stays 0.
- Data write addr 0x01000100, size 0, wdata 0xAB, m_req_ready low 3 cycles → m_* fields stable through stall, d_resp_valid pulse after ack, d_resp_data=0.
- Both valid continuously, STARVE_LIMIT=4 → grant order D,D,D,D,F,D,D,D,D,F…; fetch never waits more than 4 data grants.
- STARVE_LIMIT=0, both valid → fetch wins every tie.
- Spurious m_resp_valid in IDLE and REQ → no resp pulses, state and count unchanged.
- Reset asserted in WAIT, then response arrives → no resp_valid, all outputs 0, next fetch serviced normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory buses seen by the shared-port arbiter.
// master is the arbiter side, slave is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int DATAW = 32,
    parameter int ADDRW = 32
);
    logic             if_req_valid;
    logic             if_req_ready;
    logic [ADDRW-1:0] if_addr;
    logic             if_resp_valid;
    logic [DATAW-1:0] if_resp_data;

    logic             d_req_valid;
    logic             d_req_ready;
    logic [ADDRW-1:0] d_addr;
    logic             d_rw;
    logic [1:0]       d_size;
    logic [DATAW-1:0] d_wdata;
    logic             d_resp_valid;
    logic [DATAW-1:0] d_resp_data;

    logic             m_req_valid;
    logic             m_req_ready;
    logic [ADDRW-1:0] m_addr;
    logic             m_rw;
    logic [1:0]       m_size;
    logic [DATAW-1:0] m_wdata;
    logic             m_resp_valid;
    logic [DATAW-1:0] m_resp_data;

    modport master (
        input  if_req_valid, if_addr,
        input  d_req_valid, d_addr, d_rw, d_size, d_wdata,
        input  m_req_ready, m_resp_valid, m_resp_data,
        output if_req_ready, if_resp_valid, if_resp_data,
        output d_req_ready, d_resp_valid, d_resp_data,
        output m_req_valid, m_addr, m_rw, m_size, m_wdata
    );

    modport slave (
        output if_req_valid, if_addr,
        output d_req_valid, d_addr, d_rw, d_size, d_wdata,
        output m_req_ready, m_resp_valid, m_resp_data,
        input  if_req_ready, if_resp_valid, if_resp_data,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  m_req_valid, m_addr, m_rw, m_size, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data requesters:
// data priority, bounded fetch starvation, one transaction in flight.
module mem_port_arbiter #(
    parameter int DATAW        = 32,
    parameter int ADDRW        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                reset,
    mem_port_arbiter_if.master  bus,
    output logic                busy
);
    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    logic          owner;

    logic at_limit;
    logic idle;
    logic fetch_win;
    logic data_win;

    assign at_limit  = (starve_cnt == CW'(STARVE_LIMIT));
    assign idle      = (state == IDLE) && !reset;
    assign fetch_win = bus.if_req_valid && (!bus.d_req_valid || at_limit);
    assign data_win  = bus.d_req_valid && !fetch_win;

    assign bus.if_req_ready = idle && fetch_win;
    assign bus.d_req_ready  = idle && data_win;
    assign busy             = (state != IDLE);

    always_ff @(posedge clock) begin
        bus.if_resp_valid <= 1'b0;
        bus.d_resp_valid  <= 1'b0;
        if (reset) begin
            state            <= IDLE;
            starve_cnt       <= '0;
            owner            <= 1'b0;
            bus.m_req_valid  <= 1'b0;
            bus.m_addr       <= {ADDRW{1'b0}};
            bus.m_rw         <= 1'b0;
            bus.m_size       <= 2'b00;
            bus.m_wdata      <= {DATAW{1'b0}};
            bus.if_resp_data <= {DATAW{1'b0}};
            bus.d_resp_data  <= {DATAW{1'b0}};
        end else begin
            unique case (state)
                IDLE: begin
                    if (fetch_win) begin
                        state           <= REQ;
                        owner           <= 1'b0;
                        starve_cnt      <= '0;
                        bus.m_req_valid <= 1'b1;
                        bus.m_addr      <= bus.if_addr;
                        bus.m_rw        <= 1'b0;
                        bus.m_size      <= 2'b10;
                        bus.m_wdata     <= {DATAW{1'b0}};
                    end else if (data_win) begin
                        state           <= REQ;
                        owner           <= 1'b1;
                        bus.m_req_valid <= 1'b1;
                        bus.m_addr      <= bus.d_addr;
                        bus.m_rw        <= bus.d_rw;
                        bus.m_size      <= bus.d_size;
                        bus.m_wdata     <= bus.d_wdata;
                        // only a data grant that passes over a waiting fetch counts
                        if (!bus.if_req_valid)
                            starve_cnt <= '0;
                        else if (!at_limit)
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                REQ: begin
                    if (bus.m_req_ready) begin
                        bus.m_req_valid <= 1'b0;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.m_resp_valid) begin
                        state <= IDLE;
                        if (owner) begin
                            bus.d_resp_valid <= 1'b1;
                            bus.d_resp_data  <= bus.m_rw ? {DATAW{1'b0}}
                                                         : bus.m_resp_data;
                        end else begin
                            bus.if_resp_valid <= 1'b1;
                            bus.if_resp_data  <= bus.m_resp_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed checks of the shared memory-port arbiter: latency, stalls,
// starvation bound, tie policy, spurious responses and mid-flight reset.
module tb_mem_port_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic busy;
    logic busy0;
    int   n_chk = 0;
    int   n_fail = 0;

    mem_port_arbiter_if #(.DATAW(32), .ADDRW(32)) bus ();
    mem_port_arbiter_if #(.DATAW(32), .ADDRW(32)) bus0 ();

    mem_port_arbiter #(.DATAW(32), .ADDRW(32), .STARVE_LIMIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    mem_port_arbiter #(.DATAW(32), .ADDRW(32), .STARVE_LIMIT(0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0),
        .busy  (busy0)
    );

    always #5 clock = ~clock;

    task automatic nxt();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        bus.if_req_valid = 0; bus.if_addr = '0;
        bus.d_req_valid = 0; bus.d_addr = '0; bus.d_rw = 0;
        bus.d_size = '0; bus.d_wdata = '0;
        bus.m_req_ready = 0; bus.m_resp_valid = 0; bus.m_resp_data = '0;
        bus0.if_req_valid = 0; bus0.if_addr = '0;
        bus0.d_req_valid = 0; bus0.d_addr = '0; bus0.d_rw = 0;
        bus0.d_size = '0; bus0.d_wdata = '0;
        bus0.m_req_ready = 0; bus0.m_resp_valid = 0; bus0.m_resp_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clock);
        nxt(); #1;
        n_chk++;
        if ({bus.if_req_ready, bus.d_req_ready, bus.if_resp_valid,
             bus.d_resp_valid, bus.m_req_valid, bus.m_rw, busy} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b want 0",
                {bus.if_req_ready, bus.d_req_ready, bus.if_resp_valid,
                 bus.d_resp_valid, bus.m_req_valid, bus.m_rw, busy});
        end
        n_chk++;
        if ({bus.m_addr, bus.m_size, bus.m_wdata, bus.if_resp_data,
             bus.d_resp_data} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h/%h want 0",
                bus.m_addr, bus.m_wdata, bus.if_resp_data);
        end
        reset = 0;
    endtask

    task automatic test_lone_fetch();
        nxt();
        bus.if_req_valid = 1; bus.if_addr = 32'h0100_0000;
        bus.m_req_ready = 1; #1;
        n_chk++;
        if (bus.if_req_ready !== 1'b1 || bus.d_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL fetch_grant: got if=%b d=%b want 1 0",
                bus.if_req_ready, bus.d_req_ready);
        end
        nxt(); bus.if_req_valid = 0; #1;
        n_chk++;
        if (bus.m_req_valid !== 1'b1 || bus.m_addr !== 32'h0100_0000 ||
            bus.m_rw !== 1'b0 || bus.m_size !== 2'b10 || busy !== 1'b1) begin
            n_fail++; $display("FAIL fetch_req: got v=%b a=%h rw=%b sz=%0d",
                bus.m_req_valid, bus.m_addr, bus.m_rw, bus.m_size);
        end
        nxt(); bus.m_req_ready = 0; bus.m_resp_valid = 1;
        bus.m_resp_data = 32'h0000_0013; #1;
        n_chk++;
        if (bus.m_req_valid !== 1'b0 || bus.if_resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL fetch_wait: got mv=%b rv=%b want 0 0",
                bus.m_req_valid, bus.if_resp_valid);
        end
        nxt(); bus.m_resp_valid = 0; bus.m_resp_data = '0; #1;
        n_chk++;
        if (bus.if_resp_valid !== 1'b1 || bus.if_resp_data !== 32'h13 ||
            bus.d_resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL fetch_resp: got v=%b d=%h dv=%b",
                bus.if_resp_valid, bus.if_resp_data, bus.d_resp_valid);
        end
        nxt(); #1;
        n_chk++;
        if (bus.if_resp_valid !== 1'b0 || bus.if_resp_data !== 32'h13) begin
            n_fail++; $display("FAIL fetch_pulse: got v=%b d=%h want 0 13",
                bus.if_resp_valid, bus.if_resp_data);
        end
    endtask

    task automatic test_write_stall();
        nxt();
        bus.d_req_valid = 1; bus.d_addr = 32'h0100_0100; bus.d_rw = 1;
        bus.d_size = 2'b00; bus.d_wdata = 32'hAB; #1;
        n_chk++;
        if (bus.d_req_ready !== 1'b1 || bus.if_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL write_grant: got d=%b want 1",
                bus.d_req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            nxt();
            bus.d_req_valid = 0; bus.d_addr = '1; bus.d_wdata = '1;
            bus.m_req_ready = (i == 3); #1;
            n_chk++;
            if (bus.m_req_valid !== 1'b1 || bus.m_addr !== 32'h0100_0100 ||
                bus.m_rw !== 1'b1 || bus.m_size !== 2'b00 ||
                bus.m_wdata !== 32'hAB) begin
                n_fail++; $display("FAIL write_stall%0d: got v=%b a=%h w=%h",
                    i, bus.m_req_valid, bus.m_addr, bus.m_wdata);
            end
        end
        nxt(); bus.m_req_ready = 0; bus.m_resp_valid = 1;
        bus.m_resp_data = 32'hDEAD_BEEF; #1;
        n_chk++;
        if (bus.m_req_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL write_wait: got v=%b busy=%b want 0 1",
                bus.m_req_valid, busy);
        end
        nxt(); bus.m_resp_valid = 0; #1;
        n_chk++;
        if (bus.d_resp_valid !== 1'b1 || bus.d_resp_data !== 32'h0 ||
            bus.if_resp_valid !== 1'b0 || bus.if_resp_data !== 32'h13) begin
            n_fail++; $display("FAIL write_ack: got v=%b d=%h ifd=%h",
                bus.d_resp_valid, bus.d_resp_data, bus.if_resp_data);
        end
    endtask

    task automatic test_starvation();
        logic exp_f [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int   g = 0;
        int   budget = 100;
        nxt(); reset = 1;
        nxt(); reset = 0;
        bus.if_req_valid = 1; bus.if_addr = 32'h0100_0040;
        bus.d_req_valid = 1; bus.d_addr = 32'h0100_0800; bus.d_rw = 0;
        bus.d_size = 2'b10;
        bus.m_req_ready = 1; bus.m_resp_valid = 1; bus.m_resp_data = 32'h1;
        while (g < 10 && budget > 0) begin
            #1;
            if (bus.if_req_ready || bus.d_req_ready) begin
                n_chk++;
                if (bus.if_req_ready !== exp_f[g] ||
                    bus.d_req_ready !== !exp_f[g]) begin
                    n_fail++; $display("FAIL starve_grant%0d: got f=%b d=%b want f=%b",
                        g, bus.if_req_ready, bus.d_req_ready, exp_f[g]);
                end
                g++;
            end
            budget--;
            nxt();
        end
        n_chk++;
        if (g != 10) begin
            n_fail++; $display("FAIL starve_budget: got %0d grants want 10", g);
        end
        bus.if_req_valid = 0; bus.d_req_valid = 0;
        repeat (4) nxt();
        bus.m_req_ready = 0; bus.m_resp_valid = 0; #1;
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL starve_drain: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_limit_zero();
        int g = 0;
        int budget = 40;
        bus0.if_req_valid = 1; bus0.if_addr = 32'h0100_0000;
        bus0.d_req_valid = 1; bus0.d_addr = 32'h0100_0100;
        bus0.m_req_ready = 1; bus0.m_resp_valid = 1;
        while (g < 4 && budget > 0) begin
            #1;
            if (bus0.if_req_ready || bus0.d_req_ready) begin
                n_chk++;
                if (bus0.if_req_ready !== 1'b1 || bus0.d_req_ready !== 1'b0) begin
                    n_fail++; $display("FAIL tie0_grant%0d: got f=%b d=%b want 1 0",
                        g, bus0.if_req_ready, bus0.d_req_ready);
                end
                g++;
            end
            budget--;
            nxt();
        end
        n_chk++;
        if (g != 4) begin
            n_fail++; $display("FAIL tie0_budget: got %0d grants want 4", g);
        end
        bus0.if_req_valid = 0; bus0.d_req_valid = 0;
        repeat (4) nxt();
        bus0.m_req_ready = 0; bus0.m_resp_valid = 0;
    endtask

    task automatic test_spurious();
        nxt(); bus.m_resp_valid = 1; bus.m_resp_data = 32'h66; #1;
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL spur_idle: got busy=%b want 0", busy);
        end
        nxt(); bus.m_resp_valid = 0;
        bus.d_req_valid = 1; bus.d_addr = 32'h0100_0200; bus.d_rw = 0;
        bus.d_size = 2'b10; #1;
        n_chk++;
        if (bus.if_resp_valid !== 1'b0 || bus.d_resp_valid !== 1'b0 ||
            bus.d_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL spur_idle_resp: got iv=%b dv=%b rdy=%b",
                bus.if_resp_valid, bus.d_resp_valid, bus.d_req_ready);
        end
        nxt(); bus.d_req_valid = 0; bus.m_resp_valid = 1; #1;
        nxt(); bus.m_resp_valid = 0; #1;
        n_chk++;
        if (bus.m_req_valid !== 1'b1 || busy !== 1'b1 ||
            bus.d_resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL spur_req: got mv=%b busy=%b dv=%b",
                bus.m_req_valid, busy, bus.d_resp_valid);
        end
        bus.m_req_ready = 1;
        nxt(); bus.m_req_ready = 0; bus.m_resp_valid = 1;
        bus.m_resp_data = 32'h55; #1;
        nxt(); bus.m_resp_valid = 0; #1;
        n_chk++;
        if (bus.d_resp_valid !== 1'b1 || bus.d_resp_data !== 32'h55) begin
            n_fail++; $display("FAIL spur_read: got v=%b d=%h want 1 55",
                bus.d_resp_valid, bus.d_resp_data);
        end
    endtask

    task automatic test_reset_in_wait();
        nxt(); bus.if_req_valid = 1; bus.if_addr = 32'h0100_0300;
        bus.m_req_ready = 1;
        nxt(); bus.if_req_valid = 0;
        nxt(); bus.m_req_ready = 0; reset = 1; #1;
        n_chk++;
        if (busy !== 1'b1 || bus.m_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_wait_state: got busy=%b mv=%b",
                busy, bus.m_req_valid);
        end
        nxt(); reset = 0; bus.m_resp_valid = 1; bus.m_resp_data = 32'h77; #1;
        n_chk++;
        if ({bus.m_req_valid, bus.m_rw, bus.m_size, busy, bus.m_addr,
             bus.if_resp_data, bus.d_resp_data} !== '0) begin
            n_fail++; $display("FAIL rst_wait_out: got a=%h ifd=%h dd=%h busy=%b",
                bus.m_addr, bus.if_resp_data, bus.d_resp_data, busy);
        end
        nxt(); bus.m_resp_valid = 0; #1;
        n_chk++;
        if (bus.if_resp_valid !== 1'b0 || bus.if_resp_data !== 32'h0) begin
            n_fail++; $display("FAIL rst_wait_noresp: got v=%b d=%h want 0 0",
                bus.if_resp_valid, bus.if_resp_data);
        end
        bus.if_req_valid = 1; bus.if_addr = 32'h0100_0400; bus.m_req_ready = 1;
        nxt(); bus.if_req_valid = 0; #1;
        n_chk++;
        if (bus.m_req_valid !== 1'b1 || bus.m_addr !== 32'h0100_0400) begin
            n_fail++; $display("FAIL rst_refetch_req: got v=%b a=%h",
                bus.m_req_valid, bus.m_addr);
        end
        nxt(); bus.m_req_ready = 0; bus.m_resp_valid = 1;
        bus.m_resp_data = 32'h99;
        nxt(); bus.m_resp_valid = 0; #1;
        n_chk++;
        if (bus.if_resp_valid !== 1'b1 || bus.if_resp_data !== 32'h99) begin
            n_fail++; $display("FAIL rst_refetch_resp: got v=%b d=%h want 1 99",
                bus.if_resp_valid, bus.if_resp_data);
        end
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_write_stall();
        test_starvation();
        test_limit_zero();
        test_spurious();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures",
            n_chk, n_fail);
        $finish;
    end
endmodule
